// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared cache-line memory port: round-robin or
// fixed-priority grant, held until the memory acks or the requester aborts.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 256,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_enable_i,
  input  logic              r0_write_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_data_i,
  output logic [DATA_W-1:0] r0_data_o,
  output logic              r0_ack_o,
  input  logic              r1_enable_i,
  input  logic              r1_write_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_data_i,
  output logic [DATA_W-1:0] r1_data_o,
  output logic              r1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;

  logic [1:0]             req_en, req_wr;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_data;
  logic                   gnt_vld, gnt_id;

  assign req_en   = {r1_enable_i, r0_enable_i};
  assign req_wr   = {r1_write_i,  r0_write_i};
  assign req_addr = {r1_addr_i,   r0_addr_i};
  assign req_data = {r1_data_i,   r0_data_i};

  assign gnt_vld = (state != IDLE);
  assign gnt_id  = (state == GNT1);

  // last resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (req_en == 2'b11)
          state_nxt = ((FIXED_PRIO != 0) || last) ? GNT0 : GNT1;
        else if (req_en[0])
          state_nxt = GNT0;
        else if (req_en[1])
          state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        // ack wins over a same-cycle enable drop; an abort leaves last alone
        if (mem_ack_i) begin
          state_nxt = IDLE;
          last_nxt  = gnt_id;
        end else if (!req_en[gnt_id]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_enable_o = gnt_vld & req_en[gnt_id];
  assign mem_write_o  = gnt_vld & req_wr[gnt_id];
  assign mem_addr_o   = gnt_vld ? req_addr[gnt_id] : '0;
  assign mem_data_o   = gnt_vld ? req_data[gnt_id] : '0;

  assign r0_ack_o  = mem_ack_i & (state == GNT0);
  assign r1_ack_o  = mem_ack_i & (state == GNT1);
  assign r0_data_o = mem_data_i;
  assign r1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-vector bench for mem_arbiter: round-robin instance driven from a table,
// fixed-priority instance checked by a short hand-written sequence.
module tb_mem_arbiter;

  localparam logic [31:0]  A0 = 32'h0000_0400;
  localparam logic [31:0]  A1 = 32'h0000_1420;
  localparam logic [31:0]  AF = 32'h0000_0020;
  localparam logic [255:0] D0 = {32{8'h11}};
  localparam logic [255:0] D1 = {32{8'hA5}};

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         r0_enable_i = 1'b0, r0_write_i = 1'b0;
  logic [31:0]  r0_addr_i = A0;
  logic [255:0] r0_data_i = D0;
  logic         r1_enable_i = 1'b0, r1_write_i = 1'b0;
  logic [31:0]  r1_addr_i = A1;
  logic [255:0] r1_data_i = D1;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  logic [255:0] r0_data_o, r1_data_o, mem_data_o;
  logic         r0_ack_o, r1_ack_o, mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;

  logic [255:0] fp_r0_data, fp_r1_data, fp_mem_data;
  logic         fp_r0_ack, fp_r1_ack, fp_mem_en, fp_mem_wr;
  logic [31:0]  fp_mem_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.ADDR_W(32), .DATA_W(256), .FIXED_PRIO(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .r0_enable_i(r0_enable_i), .r0_write_i(r0_write_i), .r0_addr_i(r0_addr_i),
    .r0_data_i(r0_data_i), .r0_data_o(r0_data_o), .r0_ack_o(r0_ack_o),
    .r1_enable_i(r1_enable_i), .r1_write_i(r1_write_i), .r1_addr_i(r1_addr_i),
    .r1_data_i(r1_data_i), .r1_data_o(r1_data_o), .r1_ack_o(r1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(256), .FIXED_PRIO(1)) dut_fp (
    .clk_i(clk_i), .rst_i(rst_i),
    .r0_enable_i(r0_enable_i), .r0_write_i(r0_write_i), .r0_addr_i(r0_addr_i),
    .r0_data_i(r0_data_i), .r0_data_o(fp_r0_data), .r0_ack_o(fp_r0_ack),
    .r1_enable_i(r1_enable_i), .r1_write_i(r1_write_i), .r1_addr_i(r1_addr_i),
    .r1_data_i(r1_data_i), .r1_data_o(fp_r1_data), .r1_ack_o(fp_r1_ack),
    .mem_enable_o(fp_mem_en), .mem_write_o(fp_mem_wr), .mem_addr_o(fp_mem_addr),
    .mem_data_o(fp_mem_data), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  typedef struct {
    int          rep;
    logic        rst, en0, en1, w1;
    logic [31:0] a1;
    logic        ack;
    logic        men, mw;
    logic [1:0]  sel;   // 0 = idle, 1 = r0 driving memory, 2 = r1 driving memory
    logic        k0, k1;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(int rep, logic rst, logic en0, logic en1, logic w1,
                              logic [31:0] a1, logic ack, logic men, logic mw,
                              logic [1:0] sel, logic k0, logic k1);
    vec_t v;
    v.rep = rep; v.rst = rst; v.en0 = en0; v.en1 = en1; v.w1 = w1; v.a1 = a1;
    v.ack = ack; v.men = men; v.mw = mw; v.sel = sel; v.k0 = k0; v.k1 = k1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    // single r0 read, ack 10 cycles after enable
    vec.push_back(mk(1, 1,1,0,0,A1,0, 0,0,0,0,0));
    vec.push_back(mk(9, 1,1,0,0,A1,0, 1,0,1,0,0));
    vec.push_back(mk(1, 1,1,0,0,A1,1, 1,0,1,1,0));
    vec.push_back(mk(1, 1,0,0,0,A1,0, 0,0,0,0,0));
    // reset, then both requesting: r0,r1,r0,r1,r0,r1 with one idle gap each
    vec.push_back(mk(2, 0,0,0,0,A1,0, 0,0,0,0,0));
    for (int t = 0; t < 6; t++) begin
      vec.push_back(mk(1, 1,1,1,0,A1,0, 0,0,0,0,0));
      vec.push_back(mk(1, 1,1,1,0,A1,0, 1,0,(t%2==0)?2'd1:2'd2,0,0));
      vec.push_back(mk(1, 1,1,1,0,A1,1, 1,0,(t%2==0)?2'd1:2'd2,(t%2==0),(t%2==1)));
    end
    // r1 write-back, then fill while r0 also requests (last=1 -> r0 first)
    vec.push_back(mk(1, 1,0,1,1,A1,0, 0,0,0,0,0));
    vec.push_back(mk(2, 1,0,1,1,A1,0, 1,1,2,0,0));
    vec.push_back(mk(1, 1,0,1,1,A1,1, 1,1,2,0,1));
    vec.push_back(mk(1, 1,1,1,0,AF,0, 0,0,0,0,0));
    vec.push_back(mk(1, 1,1,1,0,AF,0, 1,0,1,0,0));
    vec.push_back(mk(1, 1,1,1,0,AF,1, 1,0,1,1,0));
    vec.push_back(mk(1, 1,0,1,0,AF,0, 0,0,0,0,0));
    vec.push_back(mk(1, 1,0,1,0,AF,1, 1,0,2,0,1));
    vec.push_back(mk(1, 1,0,0,0,AF,0, 0,0,0,0,0));
    // r1 abort 3 cycles in, late ack ignored, tie goes to r0
    vec.push_back(mk(1, 1,0,1,0,A1,0, 0,0,0,0,0));
    vec.push_back(mk(3, 1,0,1,0,A1,0, 1,0,2,0,0));
    vec.push_back(mk(1, 1,0,0,0,A1,0, 0,0,2,0,0));
    vec.push_back(mk(1, 1,0,0,0,A1,1, 0,0,0,0,0));
    vec.push_back(mk(1, 1,1,1,0,A1,0, 0,0,0,0,0));
    vec.push_back(mk(1, 1,1,1,0,A1,1, 1,0,1,1,0));
    // with last=0, r1 abort must keep last=0 so the next tie goes to r1
    vec.push_back(mk(1, 1,0,1,0,A1,0, 0,0,0,0,0));
    vec.push_back(mk(1, 1,0,1,0,A1,0, 1,0,2,0,0));
    vec.push_back(mk(1, 1,0,0,0,A1,0, 0,0,2,0,0));
    vec.push_back(mk(1, 1,1,1,0,A1,0, 0,0,0,0,0));
    vec.push_back(mk(1, 1,1,1,0,A1,1, 1,0,2,0,1));
    // r0 drops enable in its ack cycle: still a completion, last becomes 0
    vec.push_back(mk(1, 1,1,1,0,A1,0, 0,0,0,0,0));
    vec.push_back(mk(1, 1,0,1,0,A1,1, 0,0,1,1,0));
    vec.push_back(mk(1, 1,1,1,0,A1,0, 0,0,0,0,0));
    vec.push_back(mk(1, 1,1,1,0,A1,1, 1,0,2,0,1));
    // reset during GNT0 with an ack pending, then r1 granted after 1 cycle
    vec.push_back(mk(1, 1,1,1,0,A1,0, 0,0,0,0,0));
    vec.push_back(mk(1, 1,1,1,0,A1,0, 1,0,1,0,0));
    vec.push_back(mk(2, 0,1,1,0,A1,1, 0,0,0,0,0));
    vec.push_back(mk(1, 1,0,1,0,A1,0, 0,0,0,0,0));
    vec.push_back(mk(1, 1,0,1,0,A1,1, 1,0,2,0,1));
    vec.push_back(mk(1, 1,0,0,0,A1,0, 0,0,0,0,0));

    // reset state
    #1;
    chk("reset.men", {255'd0, mem_enable_o}, 256'd0);
    chk("reset.addr", {224'd0, mem_addr_o}, 256'd0);
    repeat (2) @(negedge clk_i);

    foreach (vec[i]) begin
      for (int r = 0; r < vec[i].rep; r++) begin
        logic [31:0]  ea;
        logic [255:0] ed;
        @(negedge clk_i);
        rst_i       = vec[i].rst;
        r0_enable_i = vec[i].en0;
        r1_enable_i = vec[i].en1;
        r1_write_i  = vec[i].w1;
        r1_addr_i   = vec[i].a1;
        mem_ack_i   = vec[i].ack;
        mem_data_i  = {8{$urandom}};
        #1;
        ea = (vec[i].sel == 2'd1) ? A0 : (vec[i].sel == 2'd2) ? vec[i].a1 : 32'd0;
        ed = (vec[i].sel == 2'd1) ? D0 : (vec[i].sel == 2'd2) ? D1 : 256'd0;
        chk($sformatf("v%0d.%0d.men", i, r), {255'd0, mem_enable_o}, {255'd0, vec[i].men});
        chk($sformatf("v%0d.%0d.mw", i, r), {255'd0, mem_write_o}, {255'd0, vec[i].mw});
        chk($sformatf("v%0d.%0d.addr", i, r), {224'd0, mem_addr_o}, {224'd0, ea});
        chk($sformatf("v%0d.%0d.wdata", i, r), mem_data_o, ed);
        chk($sformatf("v%0d.%0d.ack0", i, r), {255'd0, r0_ack_o}, {255'd0, vec[i].k0});
        chk($sformatf("v%0d.%0d.ack1", i, r), {255'd0, r1_ack_o}, {255'd0, vec[i].k1});
        if (vec[i].k0 || vec[i].k1) begin
          chk($sformatf("v%0d.%0d.rdata0", i, r), r0_data_o, mem_data_i);
          chk($sformatf("v%0d.%0d.rdata1", i, r), r1_data_o, mem_data_i);
        end
      end
    end

    // fixed priority: r0 wins every tie until it drops enable
    @(negedge clk_i);
    rst_i = 1'b0; r0_enable_i = 1'b0; r1_enable_i = 1'b0; r1_write_i = 1'b0;
    r1_addr_i = A1; mem_ack_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1; r0_enable_i = 1'b1; r1_enable_i = 1'b1;
    #1;
    chk("fp.idle0", {255'd0, fp_mem_en}, 256'd0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk_i);
      mem_ack_i = 1'b1;
      #1;
      chk($sformatf("fp.t%0d.men", t), {255'd0, fp_mem_en}, 256'd1);
      chk($sformatf("fp.t%0d.addr", t), {224'd0, fp_mem_addr}, {224'd0, A0});
      chk($sformatf("fp.t%0d.ack0", t), {255'd0, fp_r0_ack}, 256'd1);
      chk($sformatf("fp.t%0d.ack1", t), {255'd0, fp_r1_ack}, 256'd0);
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (t == 2) r0_enable_i = 1'b0;
      #1;
      chk($sformatf("fp.t%0d.gap", t), {255'd0, fp_mem_en}, 256'd0);
    end
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    #1;
    chk("fp.r1.men", {255'd0, fp_mem_en}, 256'd1);
    chk("fp.r1.addr", {224'd0, fp_mem_addr}, {224'd0, A1});
    chk("fp.r1.ack1", {255'd0, fp_r1_ack}, 256'd1);
    @(negedge clk_i);
    mem_ack_i = 1'b0; r1_enable_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
